// File: rtl/patch_reducer_scheduler.sv
// Round-robin scheduler that feeds row sums into a pool of patch reducers and
// returns their results downstream in patch order, tagged with a sequence number.
module patch_reducer_scheduler #(
    parameter int N_REDUCER  = 4,
    parameter int PATCH_SIZE = 6,
    parameter int FP_SIZE    = 32
) (
    input  logic                             dram_clk,
    input  logic                             reset,
    input  logic                             patch_start,
    output logic                             patch_start_ack,
    output logic                             row_ready,
    input  logic                             row_valid,
    input  logic [FP_SIZE-1:0]               row_sum,
    output logic [N_REDUCER-1:0]             red_init,
    output logic [FP_SIZE-1:0]               red_partial_sum,
    output logic [2*N_REDUCER-1:0]           red_partial_sum_valid,
    input  logic [N_REDUCER-1:0]             red_sum_rdy,
    input  logic [N_REDUCER*FP_SIZE-1:0]     red_sum,
    output logic [N_REDUCER-1:0]             red_sum_ack,
    output logic                             sum_valid,
    output logic [FP_SIZE-1:0]               sum,
    output logic [7:0]                       sum_tag,
    input  logic                             sum_ack,
    output logic                             busy,
    output logic                             dbg_feed_state,
    output logic                             dbg_out_state,
    output logic [$clog2(N_REDUCER+1)-1:0]   dbg_occupancy
);

    localparam int IDX_W = $clog2(N_REDUCER);
    localparam int OCC_W = $clog2(N_REDUCER + 1);
    localparam int ROW_W = $clog2(PATCH_SIZE + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(N_REDUCER);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PATCH_SIZE - 1);

    typedef enum logic {IDLE, FEED} feed_state_t;
    typedef enum logic {OUT_WAIT, OUT_HOLD} out_state_t;

    feed_state_t feed_state, feed_next;
    out_state_t  out_state, out_next;

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [OCC_W-1:0] occupancy;
    logic [7:0]       wr_tag, rd_tag;
    logic [ROW_W-1:0] row_cnt;

    logic alloc, accept, last_row, take, retire;
    logic [N_REDUCER-1:0]   init_d, rsa_d;
    logic [2*N_REDUCER-1:0] pv_d;

    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            feed_state <= IDLE;
            out_state  <= OUT_WAIT;
        end else begin
            feed_state <= feed_next;
            out_state  <= out_next;
        end
    end

    always_comb begin
        feed_next = feed_state;
        out_next  = out_state;
        case (feed_state)
            IDLE:    if (alloc)    feed_next = FEED;
            FEED:    if (last_row) feed_next = IDLE;
            default: feed_next = IDLE;
        endcase
        case (out_state)
            OUT_WAIT: if (take)   out_next = OUT_HOLD;
            OUT_HOLD: if (retire) out_next = OUT_WAIT;
            default:  out_next = OUT_WAIT;
        endcase
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; row_ready = FEED, sum_ack only counts while sum_valid is high.
    // A retire in the same cycle frees the slot, so a full pool may allocate.
    always_comb begin
        retire   = (out_state == OUT_HOLD) && sum_ack;
        alloc    = (feed_state == IDLE) && patch_start && ((occupancy < OCC_FULL) || retire);
        accept   = (feed_state == FEED) && row_valid;
        last_row = accept && (row_cnt == ROW_LAST);
        take     = (out_state == OUT_WAIT) && (occupancy != '0) && red_sum_rdy[rd_idx];
        init_d   = '0;
        init_d[wr_idx] = alloc;
        pv_d     = '0;
        pv_d[{wr_idx, 1'b0}] = accept;
        rsa_d    = '0;
        rsa_d[rd_idx] = take;
    end

    assign row_ready      = (feed_state == FEED);
    assign sum_valid      = (out_state == OUT_HOLD);
    assign busy           = (occupancy != '0) || (feed_state != IDLE);
    assign dbg_feed_state = feed_state;
    assign dbg_out_state  = out_state;
    assign dbg_occupancy  = occupancy;

    always_ff @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            patch_start_ack       <= 1'b0;
            red_init              <= '0;
            red_partial_sum       <= '0;
            red_partial_sum_valid <= '0;
            red_sum_ack           <= '0;
            sum                   <= '0;
            sum_tag               <= '0;
            row_cnt               <= '0;
            wr_idx                <= '0;
            rd_idx                <= '0;
            wr_tag                <= '0;
            rd_tag                <= '0;
            occupancy             <= '0;
        end else begin
            patch_start_ack       <= alloc;
            red_init              <= init_d;
            red_partial_sum_valid <= pv_d;
            red_sum_ack           <= rsa_d;
            if (accept)
                red_partial_sum <= row_sum;
            if (alloc)
                row_cnt <= '0;
            else if (accept)
                row_cnt <= row_cnt + ROW_W'(1);
            if (last_row) begin
                wr_idx <= wr_idx + IDX_W'(1);
                wr_tag <= wr_tag + 8'd1;
            end
            if (take) begin
                sum     <= red_sum[rd_idx*FP_SIZE +: FP_SIZE];
                sum_tag <= rd_tag;
            end
            if (retire) begin
                rd_idx <= rd_idx + IDX_W'(1);
                rd_tag <= rd_tag + 8'd1;
            end
            case ({alloc, retire})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_patch_reducer_scheduler.sv
// Bench for patch_reducer_scheduler: behavioural reducer pool, directed patches,
// expected results queued at patch acceptance and checked by a monitor.
module tb_patch_reducer_scheduler;

    localparam int N  = 4;
    localparam int PS = 6;
    localparam int FP = 32;
    localparam int OW = $clog2(N + 1);

    logic            dram_clk = 1'b0;
    logic            reset = 1'b1;
    logic            patch_start = 1'b0;
    logic            patch_start_ack;
    logic            row_ready;
    logic            row_valid = 1'b0;
    logic [FP-1:0]   row_sum = '0;
    logic [N-1:0]    red_init;
    logic [FP-1:0]   red_partial_sum;
    logic [2*N-1:0]  red_partial_sum_valid;
    logic [N-1:0]    red_sum_rdy;
    logic [N*FP-1:0] red_sum;
    logic [N-1:0]    red_sum_ack;
    logic            sum_valid;
    logic [FP-1:0]   sum;
    logic [7:0]      sum_tag;
    logic            sum_ack;
    logic            busy;
    logic            dbg_feed_state;
    logic            dbg_out_state;
    logic [OW-1:0]   dbg_occupancy;

    patch_reducer_scheduler #(.N_REDUCER(N), .PATCH_SIZE(PS), .FP_SIZE(FP)) dut (
        .dram_clk(dram_clk), .reset(reset),
        .patch_start(patch_start), .patch_start_ack(patch_start_ack),
        .row_ready(row_ready), .row_valid(row_valid), .row_sum(row_sum),
        .red_init(red_init), .red_partial_sum(red_partial_sum),
        .red_partial_sum_valid(red_partial_sum_valid),
        .red_sum_rdy(red_sum_rdy), .red_sum(red_sum), .red_sum_ack(red_sum_ack),
        .sum_valid(sum_valid), .sum(sum), .sum_tag(sum_tag), .sum_ack(sum_ack),
        .busy(busy), .dbg_feed_state(dbg_feed_state), .dbg_out_state(dbg_out_state),
        .dbg_occupancy(dbg_occupancy)
    );

    always #5 dram_clk = ~dram_clk;

    int passed = 0;
    int total  = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  tb_tag = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural reducers: accumulate PS rows after an init, then report ready.
    logic [FP-1:0] r_acc[N];
    int            r_cnt[N];
    logic [N-1:0]  r_done;
    logic [N-1:0]  r_gate = '0;

    always @(posedge dram_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= 0;
            end
            r_done <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (red_init[i]) begin
                    r_acc[i]  <= '0;
                    r_cnt[i]  <= 0;
                    r_done[i] <= 1'b0;
                end else if (red_partial_sum_valid[2*i +: 2] == 2'b01) begin
                    r_acc[i] <= r_acc[i] + red_partial_sum;
                    if (r_cnt[i] == PS - 1) begin
                        r_cnt[i]  <= 0;
                        r_done[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1;
                    end
                end
                if (red_sum_ack[i]) r_done[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        red_sum_rdy = r_done & ~r_gate;
        red_sum = '0;
        for (int i = 0; i < N; i++) red_sum[i*FP +: FP] = r_acc[i];
    end

    // Downstream acknowledge: automatic after ack_delay valid cycles, or manual.
    logic auto_ack = 1'b1;
    logic auto_sum_ack = 1'b0;
    logic man_ack = 1'b0;
    int   ack_delay = 0;
    int   vcnt = 0;
    assign sum_ack = auto_sum_ack | man_ack;

    initial forever begin
        @(posedge dram_clk);
        #1;
        if (reset || !auto_ack || !sum_valid) begin
            vcnt = 0;
            auto_sum_ack = 1'b0;
        end else begin
            vcnt++;
            auto_sum_ack = (vcnt > ack_delay);
        end
    end

    // Monitor: scoreboard pop on each new result plus protocol checks.
    logic [$clog2(N)-1:0] init_idx;
    int         psa_cnt, rsa_cnt, res_cnt;
    int         pv_cnt[N];
    logic       prev_valid;
    logic [39:0] held;

    always @(negedge dram_clk) begin
        logic [N-1:0] ei;
        logic [1:0]   field;
        logic [39:0]  e;
        if (reset) begin
            init_idx = '0;
            psa_cnt = 0;
            rsa_cnt = 0;
            res_cnt = 0;
            prev_valid = 1'b0;
            for (int i = 0; i < N; i++) pv_cnt[i] = 0;
        end else begin
            if (patch_start_ack) psa_cnt++;
            if (red_init != '0) begin
                ei = '0;
                ei[init_idx] = 1'b1;
                check("init_idx", red_init, ei);
                check("init_free", {r_done[init_idx], r_cnt[init_idx] != 0}, 0);
                init_idx = init_idx + 1'b1;
            end
            if (red_sum_ack != '0) begin
                rsa_cnt++;
                check("rsa_onehot", $countones(red_sum_ack), 1);
            end
            for (int i = 0; i < N; i++) begin
                field = red_partial_sum_valid[2*i +: 2];
                if (field != 2'b00) begin
                    pv_cnt[i]++;
                    check("pv_field", field, 2'b01);
                end
            end
            if (sum_valid && !prev_valid) begin
                res_cnt++;
                if (exp_q.size() == 0) begin
                    check("result_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", sum, e[31:0]);
                    check("sum_tag", sum_tag, e[39:32]);
                end
                held = {sum_tag, sum};
            end else if (sum_valid) begin
                check("hold_stable", {sum_tag, sum}, held);
            end
            prev_valid = sum_valid;
        end
    end

    task automatic tick();
        @(posedge dram_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        patch_start = 1'b0;
        row_valid = 1'b0;
        row_sum = '0;
        man_ack = 1'b0;
        exp_q.delete();
        tb_tag = '0;
        repeat (2) tick();
        check("rst_ctrl", {patch_start_ack, row_ready, red_init, red_partial_sum_valid,
                           red_sum_ack, sum_valid, busy}, 0);
        check("rst_data", {sum_tag, sum, red_partial_sum}, 0);
        check("rst_state", {dbg_feed_state, dbg_out_state, dbg_occupancy}, 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic run_patch(input int first, input int step, input int exp_sum, input int nrows);
        int k;
        patch_start = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!patch_start_ack && k < 200);
        patch_start = 1'b0;
        check("start_ack", patch_start_ack, 1);
        if (!patch_start_ack) return;
        if (nrows == PS) begin
            exp_q.push_back({tb_tag, exp_sum[31:0]});
            tb_tag = tb_tag + 8'd1;
        end
        check("row_ready", row_ready, 1);
        for (int r = 0; r < nrows; r++) begin
            row_valid = 1'b1;
            row_sum = FP'(first + r * step);
            tick();
        end
        row_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || sum_valid) && k < 300) begin
            tick();
            k++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single patch of rows 1..6 into reducer 0.
        run_patch(1, 1, 21, PS);
        drain();
        check("pv_to_r0", pv_cnt[0], 6);
        check("single_init", psa_cnt, 1);
        check("idle_busy", busy, 0);

        // Reducer 1 finishes first; results must still leave in tag order.
        do_reset();
        r_gate[0] = 1'b1;
        run_patch(10, 10, 210, PS);
        run_patch(5, 3, 75, PS);
        repeat (20) tick();
        check("no_early_out", sum_valid, 0);
        r_gate = '0;
        drain();

        // Slow downstream: result held for 10 cycles, reducer acked once.
        ack_delay = 10;
        run_patch(0, 2, 30, PS);
        drain();
        ack_delay = 0;
        check("rsa_once", rsa_cnt, res_cnt);

        // Fill the pool, hold the fifth patch off, then retire+allocate together.
        do_reset();
        auto_ack = 1'b0;
        run_patch(1, 1, 21, PS);
        run_patch(2, 2, 42, PS);
        run_patch(3, 3, 63, PS);
        run_patch(4, 4, 84, PS);
        fork
            run_patch(7, 0, 42, PS);
            begin
                repeat (30) tick();
                check("full_no_ack", psa_cnt, 4);
                check("full_occ", dbg_occupancy, 4);
                check("full_held", sum_valid, 1);
                man_ack = 1'b1;
                tick();
                man_ack = 1'b0;
                check("swap_ack", patch_start_ack, 1);
                check("swap_occ", dbg_occupancy, 4);
                auto_ack = 1'b1;
            end
        join
        drain();
        check("rsa_match", rsa_cnt, res_cnt);

        // Reset mid-patch discards it; the next patch restarts at reducer 0, tag 0.
        run_patch(9, 1, 0, 3);
        do_reset();
        run_patch(100, 1, 615, PS);
        drain();
        check("post_rst_results", res_cnt, 1);
        check("end_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/patch_reducer_scheduler.md
PATCH_REDUCER_SCHEDULER -- requirements
Module: patch_reducer_scheduler

Interface
REQ-001 The block SHALL have parameter N_REDUCER, default 4, meaning the number of attached patch reducers (power of two, 2..16).
REQ-002 The block SHALL have parameter PATCH_SIZE, default 6, meaning the number of rows per patch.
REQ-003 The block SHALL have parameter FP_SIZE, default 32, meaning the sum width.
REQ-004 The block SHALL have port dram_clk, in, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port patch_start, in, 1, a request to open a new patch.
REQ-007 The block SHALL have port patch_start_ack, out, 1, a one-cycle pulse that accepts patch_start.
REQ-008 The block SHALL have port row_ready, out, 1, high when row sums are accepted.
REQ-009 The block SHALL have ports row_valid, in, 1 and row_sum, in, FP_SIZE, carrying one row partial sum.
REQ-010 The block SHALL have port red_init, out, N_REDUCER, a per-reducer init pulse.
REQ-011 The block SHALL have port red_partial_sum, out, FP_SIZE, broadcast to all reducers.
REQ-012 The block SHALL have port red_partial_sum_valid, out, 2*N_REDUCER, one 2-bit row-count field per reducer.
REQ-013 The block SHALL have ports red_sum_rdy, in, N_REDUCER and red_sum, in, N_REDUCER*FP_SIZE, the reducer results (reducer i at bits [i*FP_SIZE +: FP_SIZE]).
REQ-014 The block SHALL have port red_sum_ack, out, N_REDUCER, a per-reducer result acknowledge pulse.
REQ-015 The block SHALL have ports sum_valid, out, 1; sum, out, FP_SIZE; sum_tag, out, 8, the downstream result and its patch sequence number.
REQ-016 The block SHALL have port sum_ack, in, 1, the downstream acknowledge.
REQ-017 The block SHALL have port busy, out, 1, high when occupancy is nonzero or the feed FSM is not in IDLE.

Function
REQ-018 Reducers SHALL be allocated strictly round-robin: wr_idx for allocation, rd_idx for retirement, both wrapping N_REDUCER-1 -> 0. Results therefore leave in patch order.
REQ-019 An occupancy counter (0..N_REDUCER) SHALL count allocated-but-unretired reducers; simultaneous allocate and retire in one cycle leaves it unchanged.
REQ-020 The feed FSM SHALL have two states, IDLE and FEED:
- IDLE: if patch_start and occupancy < N_REDUCER, then pulse patch_start_ack and red_init[wr_idx] for one cycle (registered), clear the row counter, and go to FEED.
- IDLE with a full occupancy: patch_start is held off with no ack.
REQ-021 row_ready SHALL equal (state == FEED); row_valid while row_ready is low SHALL be ignored.
REQ-022 In FEED, each accepted row SHALL register red_partial_sum <= row_sum and red_partial_sum_valid[wr_idx field] <= 2'b01 for exactly one cycle (1-cycle latency); all other fields are 0.
REQ-023 When the PATCH_SIZE-th row is accepted, the feed FSM SHALL advance wr_idx, increment the 8-bit write tag (wrapping 255 -> 0), and return to IDLE; the next patch_start_ack comes no earlier than the following cycle.
REQ-024 The output FSM SHALL have two states, OUT_WAIT and OUT_HOLD:
- OUT_WAIT: if occupancy > 0 and red_sum_rdy[rd_idx], then latch sum <= that reducer's slice, set sum_tag to the read tag, pulse red_sum_ack[rd_idx] for one cycle, set sum_valid, and go to OUT_HOLD.
- OUT_HOLD: sum, sum_tag and sum_valid are held stable until sum_ack. On sum_ack: clear sum_valid, advance rd_idx and the read tag, decrement occupancy, and return to OUT_WAIT.
REQ-025 red_sum_rdy from any reducer other than rd_idx SHALL be ignored; red_sum_ack SHALL be at most one-hot.
REQ-026 sum_ack while sum_valid is low SHALL be ignored; the minimum result spacing SHALL be 2 cycles.
REQ-027 red_init SHALL be at most one-hot, and never issued to a reducer that is allocated and not yet retired.

Reset
REQ-028 On reset, all outputs SHALL be 0; both FSMs go to IDLE/OUT_WAIT; wr_idx, rd_idx, occupancy and both tags clear to 0. A reset mid-patch discards all in-flight patches, and no result is emitted for them.

Verification
REQ-029 Single patch, PATCH_SIZE=6, rows 1..6 -> red_init[0] pulses once, six valid pulses go to reducer 0, and sum=21 with sum_tag=0 is output after the reducer reports rdy.
REQ-030 Five back-to-back patches with N_REDUCER=4 and sum_ack held low -> four patches are accepted and the fifth patch_start gets no ack until the first sum_ack.
REQ-031 Reducer 1 finishes before reducer 0 -> no output until reducer 0 is ready; results emerge with tags 0, then 1.
REQ-032 sum_ack held low for 10 cycles -> sum and sum_tag are stable, and red_sum_ack pulsed exactly once.
REQ-033 Retire and allocate in the same cycle at occupancy 4 -> occupancy is 4 the next cycle and the new init goes to the freed index.
REQ-034 Reset asserted after row 3 of a patch -> all outputs are 0 and the next patch is allocated to reducer 0 with tag 0.
